// File: rtl/int_ctrl_if.sv
// Register-bus bundle between the bridge and the interrupt controller.
// The bridge side drives the master modport; int_ctrl uses the slave modport.
interface int_ctrl_if;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output addr, output we, output wdata, input rdata);
    modport slave  (input sel, input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller feeding CP0 HWInt.
// Latches source requests into PEND (edge or level per MODE), arbitrates
// the masked pending set while idle, and holds irq/irq_id until an EOI write.
// Build option: define INTC_RR_EN for round-robin arbitration starting after
// the last serviced id; otherwise fixed priority with bit 0 highest.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no service active; arbitrate eligible = PEND & MASK
// SVC   | irq asserted for irq_id; waits for an EOI write
module int_ctrl #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    int_ctrl_if.slave        bus,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id
);

    typedef enum logic {
        IDLE = 1'b0,
        SVC  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   src_q, src_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [N_SRC-1:0]   mode_q, mode_d;
    logic               irq_q, irq_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;

    logic               wr_pend, wr_mask, wr_eoi, wr_mode;
    logic               eoi_hit;
    logic [N_SRC-1:0]   eligible;
    logic [ID_W-1:0]    winner;
    logic               unused_wdata;

    // Only the low N_SRC write-data bits carry register content.
    assign unused_wdata = ^bus.wdata[31:N_SRC];

    // Bus write decode; writes need sel and we, reads are side-effect free.
    always_comb begin
        wr_pend = bus.sel && bus.we && (bus.addr == 2'd0);
        wr_mask = bus.sel && bus.we && (bus.addr == 2'd1);
        wr_eoi  = bus.sel && bus.we && (bus.addr == 2'd2);
        wr_mode = bus.sel && bus.we && (bus.addr == 2'd3);
        eoi_hit = (state_q == SVC) && wr_eoi;
    end

    // MASK/MODE updates and raw source sampling.
    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        src_d  = src_irq;
        if (wr_mask) mask_d = bus.wdata[N_SRC-1:0];
        if (wr_mode) mode_d = bus.wdata[N_SRC-1:0];
    end

    // Pending latch: edge bits hold until W1C or EOI (a new rise wins), level bits track the source.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (mode_q[i]) begin
                if (wr_pend && bus.wdata[i])                   pend_d[i] = 1'b0;
                if (eoi_hit && (irq_id_q == ID_W'(i)))         pend_d[i] = 1'b0;
                if (src_irq[i] && !src_q[i])                   pend_d[i] = 1'b1;
            end else begin
                pend_d[i] = src_irq[i];
            end
        end
    end

    assign eligible = pend_q & mask_q;

`ifdef INTC_RR_EN
    logic [ID_W-1:0]    last_id_q, last_id_d;
    int                 rr_start;
    logic [2*N_SRC-1:0] rr_dbl;
    logic [N_SRC-1:0]   rr_rot;

    // Remember the id retired by the most recent EOI; the next search starts just after it.
    always_comb begin
        last_id_d = last_id_q;
        if (eoi_hit) last_id_d = irq_id_q;
    end

    // Round-robin pick: rotate eligible so bit 0 is the search start, take the first set bit.
    always_comb begin
        rr_start = (int'(last_id_q) + 1) % N_SRC;
        rr_dbl   = {eligible, eligible};
        rr_rot   = N_SRC'(rr_dbl >> rr_start);
        winner   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (rr_rot[k]) winner = ID_W'((rr_start + k) % N_SRC);
        end
    end

    // last_id register; resets so the first search begins at id 0.
    always_ff @(posedge clk) begin
        if (reset) last_id_q <= ID_W'(N_SRC - 1);
        else       last_id_q <= last_id_d;
    end
`else
    // Fixed priority: descending scan so the lowest eligible index is assigned last and wins.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end
`endif

    // Service FSM: grab a winner in IDLE, hold irq/irq_id frozen in SVC until EOI.
    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    irq_id_d = winner;
                    irq_d    = 1'b1;
                    state_d  = SVC;
                end
            end
            SVC: begin
                if (wr_eoi) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register read mux, combinational from addr only.
    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            2'd0: bus.rdata = 32'(pend_q);
            2'd1: bus.rdata = 32'(mask_q);
            2'd2: bus.rdata = {irq_q, 23'b0, 8'(irq_id_q)};
            2'd3: bus.rdata = 32'(mode_q);
            default: bus.rdata = '0;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            src_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            mode_q   <= '0;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
        end
    end

    assign irq    = irq_q;
    assign irq_id = irq_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenario tasks plus a randomized run checked
// against a behavioural model of the controller kept in the bench.
module tb_int_ctrl;
    localparam int N_SRC = 4;
    localparam int ID_W  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_SRC-1:0] src_irq;
    logic             irq;
    logic [ID_W-1:0]  irq_id;

    int errors = 0;
    int checks = 0;

    int_ctrl_if bus ();

    int_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .bus     (bus),
        .irq     (irq),
        .irq_id  (irq_id)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit [3:0] m_pend, m_mask, m_mode, m_srcq;
    bit       m_busy;
    int       m_id, m_last;

    function automatic int pick(bit [3:0] e);
`ifdef INTC_RR_EN
        for (int k = 0; k < N_SRC; k++) begin
            int j;
            j = (m_last + 1 + k) % N_SRC;
            if (e[j]) return j;
        end
`else
        for (int j = 0; j < N_SRC; j++) if (e[j]) return j;
`endif
        return -1;
    endfunction

    function automatic logic [31:0] model_read(logic [1:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a)
            2'd0: r[3:0] = m_pend;
            2'd1: r[3:0] = m_mask;
            2'd2: begin r[31] = m_busy; r[7:0] = 8'(m_id); end
            default: r[3:0] = m_mode;
        endcase
        return r;
    endfunction

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        bit [3:0] np;
        bit eoi, w1c;
        int w;
        if (reset) begin
            m_pend = 0; m_mask = 0; m_mode = 0; m_srcq = 0;
            m_busy = 0; m_id = 0; m_last = N_SRC - 1;
            return;
        end
        eoi = bus.sel && bus.we && bus.addr == 2'd2;
        w1c = bus.sel && bus.we && bus.addr == 2'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (m_mode[i]) begin
                np[i] = m_pend[i];
                if (w1c && bus.wdata[i]) np[i] = 0;
                if (m_busy && eoi && m_id == i) np[i] = 0;
                if (src_irq[i] && !m_srcq[i]) np[i] = 1;
            end else begin
                np[i] = src_irq[i];
            end
        end
        if (!m_busy) begin
            w = pick(m_pend & m_mask);
            if (w >= 0) begin m_busy = 1; m_id = w; end
        end else if (eoi) begin
            m_busy = 0;
            m_last = m_id;
        end
        if (bus.sel && bus.we && bus.addr == 2'd1) m_mask = bus.wdata[3:0];
        if (bus.sel && bus.we && bus.addr == 2'd3) m_mode = bus.wdata[3:0];
        m_pend = np;
        m_srcq = src_irq;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic bus_write(logic [1:0] a, logic [31:0] d);
        bus.sel = 1; bus.we = 1; bus.addr = a; bus.wdata = d;
        cycle();
        bus.sel = 0; bus.we = 0; bus.wdata = 0;
    endtask

    task automatic do_reset();
        reset = 1; src_irq = 0;
        cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; src_irq = 4'hF;
        cycle(); cycle();
        src_irq = 0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", irq); end
        checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d exp 0", irq_id); end
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a); #1;
            checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h exp 0", a, bus.rdata); end
        end
        cycle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_hold_irq: got %b exp 0", irq); end
        reset = 0;
    endtask

    task automatic test_edge_basic();
        do_reset();
        bus_write(2'd1, 32'h1);
        bus_write(2'd3, 32'h1);
        src_irq = 4'b0001;
        cycle();
        src_irq = 0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_early: got %b exp 0", irq); end
        cycle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq: got %b exp 1", irq); end
        checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL edge_id: got %0d exp 0", irq_id); end
        bus_write(2'd2, 32'h0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_eoi_irq: got %b exp 0", irq); end
        bus.addr = 2'd0; #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL edge_eoi_pend: got %h exp 0", bus.rdata); end
    endtask

    task automatic test_priority();
        do_reset();
        bus_write(2'd1, 32'hF);
        bus_write(2'd3, 32'hF);
        src_irq = 4'b1010;
        cycle();
        src_irq = 0;
        cycle();
        checks++; if (irq !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL prio_first: got irq=%b id=%0d exp irq=1 id=1", irq, irq_id); end
        bus_write(2'd2, 32'h0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_gap: got %b exp 0", irq); end
        cycle();
        checks++; if (irq !== 1'b1 || irq_id !== 3'd3) begin errors++; $display("FAIL prio_second: got irq=%b id=%0d exp irq=1 id=3", irq, irq_id); end
        bus_write(2'd2, 32'h0);
        bus.addr = 2'd0; #1;
        checks++; if (irq !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL prio_done: got irq=%b pend=%h exp irq=0 pend=0", irq, bus.rdata); end
    endtask

    task automatic test_level();
        int n;
        do_reset();
        bus_write(2'd3, 32'h0);
        bus_write(2'd1, 32'h4);
        src_irq = 4'b0100;
        for (int s = 0; s < 4; s++) begin
            n = 0;
            while (irq !== 1'b1 && n < 10) begin cycle(); n++; end
            checks++; if (irq !== 1'b1) begin errors++; $display("FAIL level_wait%0d: got irq=%b exp 1 within 10 cycles", s, irq); end
            checks++; if (irq_id !== 3'd2) begin errors++; $display("FAIL level_id%0d: got %0d exp 2", s, irq_id); end
            if (s == 0) begin
                bus_write(2'd0, 32'h4);
                bus.addr = 2'd0; #1;
                checks++; if (bus.rdata !== 32'h4) begin errors++; $display("FAIL level_w1c_ignored: got %h exp 4", bus.rdata); end
            end
            if (s == 3) begin
                src_irq = 0;
                cycle();
                bus.addr = 2'd0; #1;
                checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL level_drop: got %h exp 0", bus.rdata); end
            end
            bus_write(2'd2, 32'h0);
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_eoi%0d: got %b exp 0", s, irq); end
        end
        cycle(); cycle(); cycle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_quiet: got %b exp 0", irq); end
    endtask

    task automatic test_mask_reset();
        do_reset();
        bus_write(2'd3, 32'hF);
        src_irq = 4'b0010;
        cycle();
        src_irq = 0;
        cycle(); cycle(); cycle();
        bus.addr = 2'd0; #1;
        checks++; if (irq !== 1'b0 || bus.rdata !== 32'h2) begin errors++; $display("FAIL mask_blocked: got irq=%b pend=%h exp irq=0 pend=2", irq, bus.rdata); end
        bus_write(2'd1, 32'h2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_latency: got %b exp 0", irq); end
        cycle();
        checks++; if (irq !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL mask_open: got irq=%b id=%0d exp irq=1 id=1", irq, irq_id); end
        reset = 1;
        cycle();
        reset = 0;
        checks++; if (irq !== 1'b0 || irq_id !== 3'd0) begin errors++; $display("FAIL midsvc_reset: got irq=%b id=%0d exp irq=0 id=0", irq, irq_id); end
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a); #1;
            checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL midsvc_reg%0d: got %h exp 0", a, bus.rdata); end
        end
        cycle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midsvc_after: got %b exp 0", irq); end
    endtask

    task automatic test_eoi_idle_set_wins();
        do_reset();
        bus_write(2'd3, 32'h1);
        src_irq = 4'b0001;
        cycle();
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus.addr = 2'd0; #1;
        checks++; if (irq !== 1'b0 || bus.rdata !== 32'h1) begin errors++; $display("FAIL eoi_idle: got irq=%b pend=%h exp irq=0 pend=1", irq, bus.rdata); end
        src_irq = 0;
        bus_write(2'd0, 32'h1);
        bus.addr = 2'd0; #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL w1c_edge: got %h exp 0", bus.rdata); end
        src_irq = 4'b0001;
        bus_write(2'd0, 32'h1);
        bus.addr = 2'd0; #1;
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL set_wins: got %h exp 1", bus.rdata); end
        bus_write(2'd0, 32'h1);
        bus.addr = 2'd0; #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL w1c_no_edge: got %h exp 0", bus.rdata); end
        src_irq = 0;
    endtask

    task automatic test_svc_writes();
        do_reset();
        bus_write(2'd3, 32'hF);
        bus_write(2'd1, 32'hF);
        src_irq = 4'b0100;
        cycle();
        src_irq = 0;
        cycle();
        bus.addr = 2'd2; #1;
        checks++; if (bus.rdata !== 32'h8000_0002) begin errors++; $display("FAIL eoi_read: got %h exp 80000002", bus.rdata); end
        bus_write(2'd1, 32'h0);
        checks++; if (irq !== 1'b1 || irq_id !== 3'd2) begin errors++; $display("FAIL svc_mask: got irq=%b id=%0d exp irq=1 id=2", irq, irq_id); end
        bus_write(2'd1, 32'hF);
        bus_write(2'd0, 32'h4);
        cycle();
        bus.addr = 2'd0; #1;
        checks++; if (irq !== 1'b1 || bus.rdata !== 32'h0) begin errors++; $display("FAIL svc_w1c: got irq=%b pend=%h exp irq=1 pend=0", irq, bus.rdata); end
        src_irq = 4'b0010;
        bus_write(2'd2, 32'h0);
        src_irq = 0;
        bus.addr = 2'd0; #1;
        checks++; if (irq !== 1'b0 || bus.rdata !== 32'h2) begin errors++; $display("FAIL eoi_new_req: got irq=%b pend=%h exp irq=0 pend=2", irq, bus.rdata); end
        cycle();
        checks++; if (irq !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL eoi_new_svc: got irq=%b id=%0d exp irq=1 id=1", irq, irq_id); end
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_arbitration();
        int exp_ids[4];
        int n;
`ifdef INTC_RR_EN
        exp_ids = '{0, 2, 0, 2};
`else
        exp_ids = '{0, 0, 0, 0};
`endif
        do_reset();
        bus_write(2'd1, 32'h5);
        src_irq = 4'b0101;
        for (int s = 0; s < 4; s++) begin
            n = 0;
            while (irq !== 1'b1 && n < 10) begin cycle(); n++; end
            checks++; if (irq !== 1'b1 || int'(irq_id) != exp_ids[s]) begin errors++; $display("FAIL arb_seq%0d: got irq=%b id=%0d exp irq=1 id=%0d", s, irq, irq_id, exp_ids[s]); end
            bus_write(2'd2, 32'h0);
        end
        src_irq = 0;
    endtask

    task automatic test_random();
        logic [31:0] exp_r;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            src_irq = 4'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            bus.sel = 0; bus.we = 0; bus.wdata = $urandom;
            bus.addr = 2'($urandom);
            if ($urandom_range(0, 9) < 4) begin
                bus.sel = ($urandom_range(0, 7) != 0);
                bus.we = 1;
                if ($urandom_range(0, 2) == 0) bus.addr = 2'd2;
            end
            cycle();
            reset = 0; bus.sel = 0; bus.we = 0;
            checks++; if (irq !== m_busy || int'(irq_id) != m_id) begin errors++; $display("FAIL rand_out@%0d: got irq=%b id=%0d exp irq=%b id=%0d", n, irq, irq_id, m_busy, m_id); end
            bus.addr = 2'($urandom); #1;
            exp_r = model_read(bus.addr);
            checks++; if (bus.rdata !== exp_r) begin errors++; $display("FAIL rand_rd@%0d addr=%0d: got %h exp %h", n, bus.addr, bus.rdata, exp_r); end
        end
    endtask

    initial begin
        reset = 1; src_irq = 0;
        bus.sel = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
        m_pend = 0; m_mask = 0; m_mode = 0; m_srcq = 0; m_busy = 0; m_id = 0; m_last = N_SRC - 1;
        @(negedge clk);
        test_reset();
        test_edge_basic();
        test_priority();
        test_level();
        test_mask_reset();
        test_eoi_idle_set_wins();
        test_svc_writes();
        test_arbitration();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
